// File: rtl/prim_subreg_shadow_bank.sv
// Bank of shadowed registers: NumWrites identical SW writes commit a value. Update, timeout and storage errors are reported.
// Latency: q_o follows the committed regs directly, qe_o/err_* one cycle after the event; no backpressure (every write is consumed).
module prim_subreg_shadow_bank #(
  parameter int unsigned   NumRegs   = 4,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   NumWrites = 2,
  parameter int unsigned   Timeout   = 0,
  parameter logic [DW-1:0] RESVAL    = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumRegs-1:0]                     sel_i,
  input  logic                                   we_i,
  input  logic [DW-1:0]                          wd_i,
  input  logic                                   re_i,
  output logic [NumRegs*DW-1:0]                  q_o,
  output logic [NumRegs-1:0]                     qe_o,
  output logic [NumRegs*$clog2(NumWrites)-1:0]   phase_o,
  output logic [NumRegs-1:0]                     err_update_o,
  output logic [NumRegs-1:0]                     err_storage_o,
  output logic                                   err_timeout_o
);

  localparam int unsigned PW   = $clog2(NumWrites);
  localparam int unsigned TW   = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam int unsigned TLim = (Timeout > 0) ? Timeout - 1 : 0;

  logic [NumRegs-1:0][DW-1:0] staged_q, staged_d;
  logic [NumRegs-1:0][DW-1:0] shadow_q, shadow_d;
  logic [NumRegs-1:0][DW-1:0] committed_q, committed_d;
  logic [NumRegs-1:0][PW-1:0] phase_q, phase_d;
  logic [NumRegs-1:0]         qe_q, qe_d, upd_q, upd_d, storage_q, storage_d, acc_vec;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic                       tmo_q, tmo_d, one_hot, bad_wr, acc_any, any_busy;

  always_comb begin
    one_hot  = $onehot(sel_i);
    bad_wr   = we_i & ~one_hot;
    acc_vec  = {NumRegs{we_i & one_hot}} & sel_i & ~storage_q;
    acc_any  = |acc_vec;
    any_busy = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      any_busy = any_busy | (phase_q[i] != '0);
    end
    // An accepted write in the expiry cycle restarts the window instead of timing out.
    tmo_d = (Timeout > 0) && any_busy && !acc_any && (tcnt_q == TW'(TLim));
    if ((Timeout == 0) || acc_any || tmo_d || !any_busy) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    staged_d    = staged_q;
    shadow_d    = shadow_q;
    committed_d = committed_q;
    phase_d     = phase_q;
    qe_d        = '0;
    upd_d       = '0;
    storage_d   = storage_q;
    for (int i = 0; i < NumRegs; i++) begin
      if (storage_q[i]) begin
        phase_d[i] = '0;
      end else if (acc_vec[i]) begin
        if (phase_q[i] == '0) begin
          staged_d[i] = ~wd_i;
          phase_d[i]  = PW'(1);
        end else if (wd_i != ~staged_q[i]) begin
          phase_d[i] = '0;
          upd_d[i]   = 1'b1;
        end else if (phase_q[i] == PW'(NumWrites - 1)) begin
          committed_d[i] = wd_i;
          shadow_d[i]    = ~wd_i;
          phase_d[i]     = '0;
          qe_d[i]        = 1'b1;
        end else begin
          phase_d[i] = phase_q[i] + 1'b1;
        end
      end else if (bad_wr && sel_i[i]) begin
        phase_d[i] = '0;
        upd_d[i]   = 1'b1;
      end else if (acc_any && (phase_q[i] != '0)) begin
        // Another channel was written mid-sequence: abort this one.
        phase_d[i] = '0;
        upd_d[i]   = 1'b1;
      end else if ((re_i && sel_i[i]) || tmo_d) begin
        phase_d[i] = '0;
      end
      storage_d[i] = storage_q[i] | (~shadow_q[i] != committed_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      staged_q    <= {NumRegs{~RESVAL}};
      shadow_q    <= {NumRegs{~RESVAL}};
      committed_q <= {NumRegs{RESVAL}};
      phase_q     <= '0;
      qe_q        <= '0;
      upd_q       <= '0;
      storage_q   <= '0;
      tcnt_q      <= '0;
      tmo_q       <= 1'b0;
    end else begin
      staged_q    <= staged_d;
      shadow_q    <= shadow_d;
      committed_q <= committed_d;
      phase_q     <= phase_d;
      qe_q        <= qe_d;
      upd_q       <= upd_d;
      storage_q   <= storage_d;
      tcnt_q      <= tcnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign q_o           = committed_q;
  assign qe_o          = qe_q;
  assign phase_o       = phase_q;
  assign err_update_o  = upd_q;
  assign err_storage_o = storage_q;
  assign err_timeout_o = tmo_q;

endmodule

// File: tb/tb_prim_subreg_shadow_bank.sv
// Scoreboarded bench for prim_subreg_shadow_bank: a per-cycle expectation queue plus a commit-event queue,
// both filled by a channel-level reference model and drained by an independent monitor.
module tb_prim_subreg_shadow_bank;
  localparam int NR = 4;
  localparam int NW = 3;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [3:0]  sel;
  logic [7:0]  wd;
  logic [31:0] q;
  logic [3:0]  qe, upd, serr;
  logic [7:0]  phase;
  logic        tmo;

  prim_subreg_shadow_bank #(
    .NumRegs(NR), .DW(8), .NumWrites(NW), .Timeout(TO), .RESVAL(8'h00)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .we_i(we), .wd_i(wd), .re_i(re),
    .q_o(q), .qe_o(qe), .phase_o(phase), .err_update_o(upd),
    .err_storage_o(serr), .err_timeout_o(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  qe;
    logic [7:0]  phase;
    logic [3:0]  upd;
    logic [3:0]  serr;
    logic        tmo;
  } exp_t;
  typedef struct {
    int         ch;
    logic [7:0] val;
  } commit_t;

  exp_t    exp_q[$];
  commit_t com_q[$];
  int      checks = 0;
  int      failures = 0;

  // Reference model: per channel the committed value, the value of the first write of
  // the running sequence and how many matching writes have been seen so far.
  logic [7:0] m_val[NR];
  logic [7:0] m_first[NR];
  int         m_cnt[NR];
  bit         m_serr[NR];
  int         m_cycle = 0;
  int         m_last_acc = -1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input logic [3:0] s, input logic [7:0] d,
                            input bit rd, input logic [3:0] bad_sh);
    exp_t    e;
    commit_t c;
    int      acc_ch;
    bit      onehot, busy, timeout;
    e.qe = '0; e.upd = '0; e.tmo = 1'b0;
    if (r) begin
      for (int i = 0; i < NR; i++) begin
        m_val[i] = 8'h00; m_cnt[i] = 0; m_serr[i] = 1'b0;
      end
    end else begin
      onehot = ($countones(s) == 1);
      acc_ch = -1;
      if (w && onehot)
        for (int i = 0; i < NR; i++) if (s[i] && !m_serr[i]) acc_ch = i;
      busy = 1'b0;
      for (int i = 0; i < NR; i++) if (m_cnt[i] > 0) busy = 1'b1;
      timeout = busy && (acc_ch < 0) && (m_cycle - m_last_acc == TO);
      for (int i = 0; i < NR; i++) begin
        if (m_serr[i]) m_cnt[i] = 0;
        else if (i == acc_ch) begin
          if (m_cnt[i] == 0) begin
            m_first[i] = d; m_cnt[i] = 1;
          end else if (d != m_first[i]) begin
            m_cnt[i] = 0; e.upd[i] = 1'b1;
          end else if (m_cnt[i] + 1 == NW) begin
            m_val[i] = d; m_cnt[i] = 0; e.qe[i] = 1'b1;
            c.ch = i; c.val = d; com_q.push_back(c);
          end else m_cnt[i] = m_cnt[i] + 1;
        end else if (w && !onehot && s[i]) begin
          m_cnt[i] = 0; e.upd[i] = 1'b1;
        end else if (acc_ch >= 0 && m_cnt[i] > 0) begin
          m_cnt[i] = 0; e.upd[i] = 1'b1;
        end else if ((rd && s[i]) || timeout) m_cnt[i] = 0;
      end
      if (acc_ch >= 0) m_last_acc = m_cycle;
      e.tmo = timeout;
      for (int i = 0; i < NR; i++) if (bad_sh[i]) m_serr[i] = 1'b1;
    end
    m_cycle++;
    for (int i = 0; i < NR; i++) begin
      e.q[i*8 +: 8]     = m_val[i];
      e.phase[i*2 +: 2] = 2'(m_cnt[i]);
      e.serr[i]         = m_serr[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit w, input logic [3:0] s, input logic [7:0] d, input bit rd);
    @(negedge clk);
    rst = r; we = w; sel = s; wd = d; re = rd;
    model_step(r, w, s, d, rd, 4'b0000);
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    drive(1'b0, 1'b1, 4'(1 << ch), d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'b0000, 8'h00, 1'b0);
  endtask

  // Monitor: drains the queues away from the active edge.
  initial begin
    exp_t    e;
    commit_t c;
    forever begin
      @(posedge clk);
      #1;
      if (qe != 4'b0000) begin
        if (com_q.size() == 0) chk("qe_unexpected", 32'(qe), 32'h0);
        else begin
          c = com_q.pop_front();
          chk("qe_channel", 32'(qe), 32'(1 << c.ch));
          chk("qe_data", 32'(q[c.ch*8 +: 8]), 32'(c.val));
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", q, e.q);
        chk("qe", 32'(qe), 32'(e.qe));
        chk("phase", 32'(phase), 32'(e.phase));
        chk("err_update", 32'(upd), 32'(e.upd));
        chk("err_storage", 32'(serr), 32'(e.serr));
        chk("err_timeout", 32'(tmo), 32'(e.tmo));
      end
    end
  end

  initial begin
    logic [31:0] fval;
    logic [7:0]  pool[2];
    int          r, cur_ch;
    bit          w, rd;
    logic [3:0]  s;
    logic [7:0]  d;
    pool[0] = 8'h3C; pool[1] = 8'hC3;
    rst = 1'b1; we = 1'b0; re = 1'b0; sel = 4'b0000; wd = 8'h00;
    for (int i = 0; i < NR; i++) begin
      m_val[i] = 8'h00; m_first[i] = 8'h00; m_cnt[i] = 0; m_serr[i] = 1'b0;
    end
    drive(1'b1, 1'b0, 4'b0000, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 8'h00, 1'b0);

    // Three matching writes commit on channel 2
    wr(2, 8'hA5); wr(2, 8'hA5); wr(2, 8'hA5); idle(2);
    chk("dir_ch2_commit", q, 32'h00A5_0000);

    // Mismatching third write
    wr(1, 8'h11); wr(1, 8'h11); wr(1, 8'h12); idle(2);
    chk("dir_ch1_unchanged", 32'(q[15:8]), 32'h00);

    // Timeout, then restart
    wr(0, 8'h33); idle(20);
    wr(0, 8'h33); wr(0, 8'h33); wr(0, 8'h33); idle(2);
    chk("dir_ch0_after_timeout", 32'(q[7:0]), 32'h33);

    // Interleave and non-one-hot select
    wr(0, 8'h44); wr(3, 8'h55); drive(1'b0, 1'b1, 4'b0101, 8'h00, 1'b0); idle(20);

    // Write lands exactly when the window expires
    wr(0, 8'h66); idle(15); wr(0, 8'h66); wr(0, 8'h66); idle(2);
    chk("dir_write_beats_timeout", 32'(q[7:0]), 32'h66);

    // Read aborts a sequence; simultaneous write beats read
    wr(2, 8'h77); drive(1'b0, 1'b0, 4'b0100, 8'h00, 1'b1);
    wr(2, 8'h77); wr(2, 8'h77); drive(1'b0, 1'b1, 4'b0100, 8'h77, 1'b1); idle(2);
    chk("dir_write_beats_read", 32'(q[23:16]), 32'h77);

    // Reset mid-sequence
    wr(0, 8'h12); wr(0, 8'h12); drive(1'b1, 1'b0, 4'b0000, 8'h00, 1'b0);
    wr(0, 8'h12); idle(2);
    chk("dir_reset_aborts", q, 32'h0);

    // Storage fault on channel 1
    @(negedge clk);
    rst = 1'b0; we = 1'b0; sel = 4'b0000; wd = 8'h00; re = 1'b0;
    fval = {~m_val[3], ~m_val[2], ~m_val[1] ^ 8'h01, ~m_val[0]};
    force dut.shadow_q = fval;
    model_step(1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0010);
    @(negedge clk);
    release dut.shadow_q;
    model_step(1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000);
    wr(1, 8'h99); wr(1, 8'h99); wr(1, 8'h99); idle(2);
    chk("dir_storage_sticky", 32'(serr), 32'h2);
    chk("dir_storage_blocks_write", 32'(q[15:8]), 32'h00);
    drive(1'b1, 1'b0, 4'b0000, 8'h00, 1'b0); idle(1);
    chk("dir_reset_clears_storage", 32'(serr), 32'h0);
    chk("dir_reset_clears_q", q, 32'h0);

    // Randomized traffic
    cur_ch = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) idle(18);
      else if (r < 3) drive(1'b1, 1'b0, 4'b0000, 8'h00, 1'b0);
      else begin
        if ($urandom_range(0, 4) == 0) cur_ch = $urandom_range(0, NR - 1);
        w  = ($urandom_range(0, 99) < 60);
        s  = ($urandom_range(0, 9) < 8) ? 4'(1 << cur_ch) : 4'($urandom_range(0, 15));
        d  = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 1)] : 8'($urandom);
        rd = ($urandom_range(0, 19) == 0);
        drive(1'b0, w, s, d, rd);
      end
    end

    idle(3);
    @(posedge clk);
    #2;
    chk("queues_drained", 32'(exp_q.size() + com_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prim_subreg_shadow_bank.md
PRIM_SUBREG_SHADOW_BANK -- requirements
Module: prim_subreg_shadow_bank

Interface
REQ-001 Parameter NumRegs, default 4, number of shadowed register channels (>=1).
REQ-002 Parameter DW, default 32, data width per channel (>=1).
REQ-003 Parameter NumWrites, default 2, identical SW writes needed to commit (2..4).
REQ-004 Parameter Timeout, default 0, max cycles between writes of one sequence; 0 disables the timeout.
REQ-005 Parameter RESVAL, default '0, DW-bit reset value, common to all channels.
REQ-006 Port clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 Port rst_i  input  1  reset, synchronous, active-high.
REQ-008 Port sel_i  input  NumRegs  channel select, expected one-hot.
REQ-009 Port we_i  input  1  SW write strobe.
REQ-010 Port wd_i  input  DW  SW write data.
REQ-011 Port re_i  input  1  SW read strobe.
REQ-012 Port q_o  output  NumRegs*DW  committed values; channel i at bits [i*DW +: DW].
REQ-013 Port qe_o  output  NumRegs  one-cycle commit pulse per channel.
REQ-014 Port phase_o  output  NumRegs*clog2(NumWrites)  per-channel write-phase count.
REQ-015 Port err_update_o  output  NumRegs  one-cycle update-error pulse per channel.
REQ-016 Port err_storage_o  output  NumRegs  sticky storage error per channel.
REQ-017 Port err_timeout_o  output  1  one-cycle timeout pulse.

Function
REQ-018 Per channel: staged reg (holds ~data), shadow reg (holds ~data), committed reg (holds data), phase counter 0..NumWrites-1.
REQ-019 Accepted write = we_i, sel_i one-hot, selected channel has err_storage_o low.
REQ-020 Accepted write at phase 0: staged <= ~wd_i, phase <= 1.
REQ-021 Accepted write at phase p>0, wd_i == ~staged, p<NumWrites-1: phase <= p+1.
REQ-022 Accepted write at phase NumWrites-1, wd_i == ~staged: committed <= wd_i, shadow <= ~wd_i, phase <= 0, qe_o pulses the next cycle.
REQ-023 Accepted write at phase p>0, wd_i != ~staged: phase <= 0, committed/shadow unchanged, err_update_o pulses the next cycle.
REQ-024 we_i with sel_i not one-hot (including zero): no register updates; err_update_o pulses the next cycle on every selected channel, and phases of selected channels clear to 0.
REQ-025 Interleave: accepted write to channel j while channel i≠j has phase>0: channel i phase <= 0, err_update_o[i] pulses the next cycle; channel j processed normally.
REQ-026 re_i clears the phase of every selected channel to 0, no error; write on the same channel in the same cycle wins over read.
REQ-027 Timeout counter (single, shared): cleared on every accepted write; increments while any phase>0; on reaching Timeout, all phases <= 0, err_timeout_o pulses the next cycle, counter clears.
REQ-028 Accepted write in the same cycle the counter reaches Timeout: write wins, no timeout, counter clears.
REQ-029 Timeout == 0: counter inactive, err_timeout_o constant 0.
REQ-030 Storage check: err_storage_o[i] set one cycle after ~shadow != committed; sticky until reset; while set, channel i ignores writes and holds phase 0.
REQ-031 q_o driven directly from committed regs, no extra latency; qe_o, err_* registered.

Reset
REQ-032 rst_i high at a clock edge: committed <= RESVAL, staged/shadow <= ~RESVAL, phases 0, counter 0, qe_o/err_update_o/err_storage_o/err_timeout_o 0.
REQ-033 Reset mid-sequence aborts the sequence; no commit, no error pulse afterwards.
REQ-034 Reset has priority over all write, read and timeout events in the same cycle.

Verification (NumRegs=4, DW=8, NumWrites=3, Timeout=16, RESVAL=0x00)
REQ-035 Three writes 0xA5 to ch2 on consecutive cycles -> phase_o[ch2] 1,2,0; qe_o[2] pulses once; q_o ch2 = 0xA5; other channels 0x00.
REQ-036 Writes 0x11, 0x11, 0x12 to ch1 -> err_update_o[1] pulses after third write; phase 0; q_o ch1 stays 0x00.
REQ-037 Write 0x33 to ch0 then 20 idle cycles -> err_timeout_o pulses 16 cycles after the write; phase 0; restart with three 0x33 commits normally.
REQ-038 Write 0x44 to ch0, then write 0x55 to ch3 -> err_update_o[0] pulses, ch0 phase 0, ch3 phase 1; we_i with sel_i=4'b0101 -> err_update_o[0] and [2] pulse, no state change elsewhere.
REQ-039 Force shadow of ch1 ≠ ~committed -> err_storage_o[1] rises next cycle, stays high; further writes to ch1 ignored; rst_i clears it and q_o returns to 0x00.
